// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period/high time of a divided clock, flags lock and stall.
// High-time measurement is built only when DIV_CLK_MONITOR_DUTY_EN is defined.
module div_clk_monitor #(
   parameter int SIZE       = 8,
   parameter int LOCK_COUNT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            enable,
   input  logic            div_in,
   output logic [SIZE-1:0] period,
   output logic [SIZE-1:0] high_time,
   output logic            valid,
   output logic            locked,
   output logic            timeout
);
   typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;
   localparam logic [SIZE-1:0] MAX = '1;
   localparam logic [SIZE-1:0] ONE = SIZE'(1);
   localparam logic [3:0]      LC  = 4'(LOCK_COUNT);
   state_t          state_q, state_d;
   logic            s1_q, s2_q, s3_q, rise, at_max;
   logic [SIZE-1:0] cnt_q, cnt_d, period_q, period_d, prev_q, prev_d;
   logic [3:0]      match_q, match_d;
   logic            valid_q, valid_d, locked_q, locked_d;
   logic            timeout_q, timeout_d, prev_ok_q, prev_ok_d;
   assign rise   = s2_q & ~s3_q;
   assign at_max = cnt_q == MAX;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
         state_q <= IDLE;
      end else begin
         s1_q <= div_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
         state_q <= state_d;
      end
   end
   always_comb begin
      state_d = !enable ? IDLE :
                (state_q == MEASURE) ? ((at_max && !rise) ? STALL : MEASURE) :
                (rise ? MEASURE : state_q);
   end
   always_comb begin
      cnt_d     = cnt_q;
      period_d  = period_q;
      prev_d    = prev_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      prev_ok_d = prev_ok_q;
      if (!enable) begin
         cnt_d     = '0;
         locked_d  = 1'b0;
         timeout_d = 1'b0;
         match_d   = '0;
         prev_ok_d = 1'b0;
      end else if (state_q == MEASURE) begin
         cnt_d = at_max ? cnt_q : cnt_q + ONE;
         if (rise) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            cnt_d     = ONE;
            match_d   = (prev_ok_q && cnt_q == prev_q) ? ((match_q == LC) ? match_q : match_q + 4'd1) : '0;
            locked_d  = match_d == LC;
            prev_d    = cnt_q;
            prev_ok_d = 1'b1;
         end else if (at_max) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            prev_ok_d = 1'b0;
         end
      end else if (rise) begin
         // a rise out of IDLE or STALL only opens a period; it is never reported
         cnt_d     = ONE;
         timeout_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         period_q  <= '0;
         prev_q    <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         prev_ok_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         prev_q    <= prev_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         prev_ok_q <= prev_ok_d;
      end
   end
`ifdef DIV_CLK_MONITOR_DUTY_EN
   logic            fall;
   logic [SIZE-1:0] hi_q, hi_d, high_q, high_d;
   assign fall = ~s2_q & s3_q;
   always_comb begin
      hi_d   = (enable && state_q == MEASURE && fall) ? cnt_q : hi_q;
      high_d = (enable && state_q == MEASURE && rise) ? hi_q : high_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q   <= '0;
         high_q <= '0;
      end else begin
         hi_q   <= hi_d;
         high_q <= high_d;
      end
   end
   assign high_time = high_q;
`else
   assign high_time = '0;
`endif
   assign period  = period_q;
   assign valid   = valid_q;
   assign locked  = locked_q;
   assign timeout = timeout_q;
endmodule
